// File: rtl/serial_mag_compare_ctrl_if.sv
// Operand-source and digit-comparator signal bundle for the serial magnitude compare controller.
// The slave side is the controller; the master side is the operand source plus the 2-bit comparator.
`timescale 1ns/1ps

interface serial_mag_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       dig_a;
    logic [1:0]       dig_b;
    logic             cmp_g;
    logic             cmp_e;
    logic             cmp_l;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             cmp_err;

    modport slave (
        input  start, op_a, op_b, cmp_g, cmp_e, cmp_l,
        output dig_a, dig_b, busy, done, gt, eq, lt, cmp_err
    );

    modport master (
        output start, op_a, op_b, cmp_g, cmp_e, cmp_l,
        input  dig_a, dig_b, busy, done, gt, eq, lt, cmp_err
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Serial unsigned compare, one 2-bit digit per cycle MSB first; done pulses k+1 cycles after start (k digits scanned).
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
`timescale 1ns/1ps

module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_mag_compare_ctrl_if.slave bus
);
    localparam int NDIG = WIDTH / 2;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] IDX_MSD = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } result_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    result_t          res_q;

    logic [1:0] a_dig [NDIG];
    logic [1:0] b_dig [NDIG];
    logic [2:0] resp;
    logic       resp_ok;

    // Digit d occupies bits [2d+1:2d]; bit 1 of each digit is its more significant bit.
    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        assign a_dig[d] = a_reg[2*d+1 : 2*d];
        assign b_dig[d] = b_reg[2*d+1 : 2*d];
    end

    assign bus.dig_a = (state == SCAN) ? a_dig[idx] : 2'b00;
    assign bus.dig_b = (state == SCAN) ? b_dig[idx] : 2'b00;

    assign resp    = {bus.cmp_g, bus.cmp_e, bus.cmp_l};
    assign resp_ok = $onehot(resp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.op_a;
                        b_reg  <= bus.op_b;
                        idx    <= IDX_MSD;
                        res_q  <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // A broken comparator response ends the scan with a neutral "equal" verdict.
                    if (!resp_ok) begin
                        err_q    <= 1'b1;
                        res_q.eq <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else if (bus.cmp_g) begin
                        res_q.gt <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else if (bus.cmp_l) begin
                        res_q.lt <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else if (idx == '0) begin
                        res_q.eq <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.gt      = res_q.gt;
    assign bus.eq      = res_q.eq;
    assign bus.lt      = res_q.lt;
    assign bus.cmp_err = err_q;

endmodule
